icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss/refill controller between CPU fetch port, direct-mapped word cache (32 lines, index addr[6:2],
//  tag addr[31:7]) and memory bus. Hits answer same cycle; misses fetch word from memory, write it into
//  the cache, then return it to the CPU. Sits directly upstream of the cache array's write port.
// PARAMETERS
//  TIMEOUT   255   max cycles waiting for i_m_ack before error; 0 = wait forever
//  CNT_W     32    width of optional statistics counters
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  i_req      in   1      CPU fetch request; held with i_addr until o_valid
//  i_addr     in   32     CPU fetch address (word aligned)
//  o_valid    out  1      fetch complete this cycle
//  o_rdata    out  32     fetch data, qualified by o_valid
//  o_err      out  1      bus timeout, qualified by o_valid
//  o_busy     out  1      controller not in IDLE
//  o_c_addr   out  32     cache lookup address
//  i_c_hit    in   1      cache hit for o_c_addr
//  i_c_rdata  in   32     cache read data for o_c_addr
//  o_c_wen    out  1      cache fill strobe
//  o_c_waddr  out  32     cache fill address
//  o_c_wdata  out  32     cache fill data
//  o_m_req    out  1      memory read request, held until acked
//  o_m_addr   out  32     memory read address
//  i_m_ack    in   1      memory ack; i_m_rdata valid same cycle
//  i_m_rdata  in   32     memory read data
//  o_hit_cnt  out  CNT_W  hit count (optional feature)
//  o_miss_cnt out  CNT_W  miss count (optional feature)
// BEHAVIOUR
//  States IDLE, REQ, FILL, RESP (registered). Reset: IDLE, all regs 0; o_valid/o_err/o_busy/o_c_wen/o_m_req=0.
//  o_c_addr = i_addr in IDLE, latched addr otherwise. o_m_addr = o_c_waddr = latched addr.
//  IDLE: i_req & i_c_hit -> o_valid=1, o_rdata=i_c_rdata combinationally, stay IDLE (0-cycle hit).
//        i_req & !i_c_hit -> latch i_addr, clear timeout counter, -> REQ.
//  REQ:  o_m_req=1. i_m_ack -> latch i_m_rdata, -> FILL. Else counter+1; counter==TIMEOUT-1 (TIMEOUT!=0)
//        -> set err flag, -> RESP (no fill).
//  FILL: o_c_wen=1 exactly one cycle, o_c_wdata=latched data -> RESP.
//  RESP: o_valid=1, o_rdata=latched data (0 on error), o_err=err flag -> IDLE; err flag cleared.
//  Min miss latency: miss in cycle 0, ack in cycle 1, fill cycle 2, o_valid cycle 3.
//  New request accepted only in IDLE; i_req in RESP cycle is not looked up until next cycle.
//  i_m_ack outside REQ ignored. Changes to i_addr while o_busy ignored (latched address used).
//  rst mid-operation: immediate IDLE, o_m_req drops next edge, no fill, no o_valid.
// CONFIGURATION
//  ICACHE_STATS_EN defined: o_hit_cnt += 1 per IDLE hit, o_miss_cnt += 1 per IDLE miss; saturating at
//  all-ones; cleared by rst. Undefined: counters not built, both ports tied 0.
// STRUCTURE
//  cache_defs.vh: state encodings, INDEX_LSB=2, INDEX_MSB=6, TAG_LSB=7 localparams.
//  Sub-module sat_counter (CNT_W, inc, rst, q) instanced twice under ICACHE_STATS_EN.
// TESTING
//  1 Hit: line 0x100 prefilled 0x1111_2222; i_req@0x100 -> o_valid same cycle, o_rdata=0x1111_2222, no o_m_req.
//  2 Miss: i_req@0x204, ack after 3 cycles, data 0xDEADBEEF -> o_m_req 3 cycles, one o_c_wen waddr 0x204,
//    o_valid in RESP with 0xDEADBEEF; repeat @0x204 -> 0-cycle hit.
//  3 Conflict: after 2, fetch 0x284 (same index 1) -> miss, refill 0x0BAD_F00D; 0x204 now misses.
//  4 Timeout: TIMEOUT=8, never ack -> o_valid & o_err 9 cycles after miss, o_rdata=0, o_c_wen never high.
//  5 Reset in REQ: rst 1 cycle, then late i_m_ack -> no o_c_wen, no o_valid, state IDLE.
//  6 Stats: 3 hits + 2 misses -> o_hit_cnt=3, o_miss_cnt=2 with ICACHE_STATS_EN; both 0 without.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller: FSM states and
// address field positions of the 32-line direct-mapped word cache.
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill,
        StResp
    } state_e;

    localparam int unsigned INDEX_LSB = 2;
    localparam int unsigned INDEX_MSB = 6;
    localparam int unsigned TAG_LSB   = 7;

    function automatic logic [INDEX_MSB-INDEX_LSB:0] line_index(input logic [31:0] addr);
        return addr[INDEX_MSB:INDEX_LSB];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating event counter used for the optional hit/miss statistics.
module icache_refill_ctrl_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill controller between CPU fetch port, direct-mapped word cache and memory bus.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             o_valid,
    output logic [31:0]      o_rdata,
    output logic             o_err,
    output logic             o_busy,
    output logic [31:0]      o_c_addr,
    input  logic             i_c_hit,
    input  logic [31:0]      i_c_rdata,
    output logic             o_c_wen,
    output logic [31:0]      o_c_waddr,
    output logic [31:0]      o_c_wdata,
    output logic             o_m_req,
    output logic [31:0]      o_m_addr,
    input  logic             i_m_ack,
    input  logic [31:0]      i_m_rdata,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] tmo_q;
    logic        err_q;
    logic        busy_q;
    logic        m_req_q;
    logic        c_wen_q;
    logic        resp_q;

    logic lookup_hit;
    logic lookup_miss;
    logic tmo_expired;

    assign lookup_hit  = (state_q == StIdle) && i_req && i_c_hit;
    assign lookup_miss = (state_q == StIdle) && i_req && !i_c_hit;
    // TIMEOUT of zero disables the bound entirely.
    assign tmo_expired = (TIMEOUT != 0) && (tmo_q == TmoLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            m_req_q <= 1'b0;
            c_wen_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lookup_miss) begin
                        addr_q  <= i_addr;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        m_req_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (i_m_ack) begin
                        data_q  <= i_m_rdata;
                        m_req_q <= 1'b0;
                        c_wen_q <= 1'b1;
                        state_q <= StFill;
                    end else if (tmo_expired) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        m_req_q <= 1'b0;
                        resp_q  <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StFill: begin
                    c_wen_q <= 1'b0;
                    resp_q  <= 1'b1;
                    state_q <= StResp;
                end
                StResp: begin
                    err_q   <= 1'b0;
                    resp_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Hits bypass the FSM and answer in the lookup cycle.
    assign o_valid   = lookup_hit || resp_q;
    assign o_rdata   = resp_q ? data_q : i_c_rdata;
    assign o_err     = resp_q && err_q;
    assign o_busy    = busy_q;
    assign o_c_addr  = busy_q ? addr_q : i_addr;
    assign o_c_wen   = c_wen_q;
    assign o_c_waddr = addr_q;
    assign o_c_wdata = data_q;
    assign o_m_req   = m_req_q;
    assign o_m_addr  = addr_q;

`ifdef ICACHE_STATS_EN
    icache_refill_ctrl_sat_counter #(
        .CNT_W(CNT_W)
    ) u_hit_cnt (
        .clk(clk),
        .rst(rst),
        .inc(lookup_hit),
        .q  (o_hit_cnt)
    );

    icache_refill_ctrl_sat_counter #(
        .CNT_W(CNT_W)
    ) u_miss_cnt (
        .clk(clk),
        .rst(rst),
        .inc(lookup_miss),
        .q  (o_miss_cnt)
    );
`else
    assign o_hit_cnt  = {CNT_W{1'b0}};
    assign o_miss_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with a behavioural cache array and memory model.
module tb_icache_refill_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             o_valid;
    logic [31:0]      o_rdata;
    logic             o_err;
    logic             o_busy;
    logic [31:0]      o_c_addr;
    logic             i_c_hit;
    logic [31:0]      i_c_rdata;
    logic             o_c_wen;
    logic [31:0]      o_c_waddr;
    logic [31:0]      o_c_wdata;
    logic             o_m_req;
    logic [31:0]      o_m_addr;
    logic             i_m_ack;
    logic [31:0]      i_m_rdata;
    logic [CNT_W-1:0] o_hit_cnt;
    logic [CNT_W-1:0] o_miss_cnt;

    icache_refill_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .o_valid   (o_valid),
        .o_rdata   (o_rdata),
        .o_err     (o_err),
        .o_busy    (o_busy),
        .o_c_addr  (o_c_addr),
        .i_c_hit   (i_c_hit),
        .i_c_rdata (i_c_rdata),
        .o_c_wen   (o_c_wen),
        .o_c_waddr (o_c_waddr),
        .o_c_wdata (o_c_wdata),
        .o_m_req   (o_m_req),
        .o_m_addr  (o_m_addr),
        .i_m_ack   (i_m_ack),
        .i_m_rdata (i_m_rdata),
        .o_hit_cnt (o_hit_cnt),
        .o_miss_cnt(o_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural cache array and backing memory.
    logic        c_valid [32];
    logic [24:0] c_tag   [32];
    logic [31:0] c_data  [32];
    logic [31:0] mem_model [logic [31:0]];

    always_comb begin
        i_c_hit   = c_valid[o_c_addr[6:2]] && (c_tag[o_c_addr[6:2]] == o_c_addr[31:7]);
        i_c_rdata = c_data[o_c_addr[6:2]];
    end

    logic [32:0] sb_q [$];   // {err, data}
    int          ack_delay;
    logic        resp_ack;
    logic        late_ack;
    int          mreq_total;
    int          wen_total;
    int          valid_total;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    assign i_m_ack = resp_ack || late_ack;

    // Monitor and memory responder, all sampling on the falling edge.
    initial begin
        int          run;
        logic [32:0] exp_item;
        run = 0;
        resp_ack = 1'b0;
        i_m_rdata = '0;
        mreq_total = 0;
        wen_total = 0;
        valid_total = 0;
        last_waddr = '0;
        last_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = '0;
            c_data[i]  = '0;
        end
        c_valid[0] = 1'b1;
        c_tag[0]   = 25'h2;
        c_data[0]  = 32'h1111_2222;
        forever begin
            @(negedge clk);
            if (o_m_req) begin
                mreq_total++;
                run++;
                resp_ack  = (ack_delay != 0) && (run == ack_delay);
                i_m_rdata = mem_model.exists(o_m_addr) ? mem_model[o_m_addr] : 32'h0;
            end else begin
                run = 0;
                resp_ack = 1'b0;
            end
            if (o_c_wen) begin
                wen_total++;
                last_waddr = o_c_waddr;
                last_wdata = o_c_wdata;
                c_valid[o_c_waddr[6:2]] = 1'b1;
                c_tag[o_c_waddr[6:2]]   = o_c_waddr[31:7];
                c_data[o_c_waddr[6:2]]  = o_c_wdata;
            end
            if (o_valid) begin
                valid_total++;
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 64'(o_valid), 64'd0);
                end else begin
                    exp_item = sb_q.pop_front();
                    check("rdata", 64'(o_rdata), 64'(exp_item[31:0]));
                    check("err", 64'(o_err), 64'(exp_item[32]));
                end
            end
        end
    end

    int exp_hits;
    int exp_misses;

    task automatic fetch(input logic [31:0] addr, input int delay, input logic hit,
                         input logic err);
        int          lat;
        int          mreq0;
        int          wen0;
        logic        seen;
        logic [31:0] data;
        data = err ? 32'h0 : mem_model[addr];
        sb_q.push_back({err, data});
        ack_delay = delay;
        if (hit) exp_hits++;
        else exp_misses++;
        @(posedge clk);
        #1;
        mreq0 = mreq_total;
        wen0  = wen_total;
        i_req  = 1'b1;
        i_addr = addr;
        seen = 1'b0;
        lat  = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        check("valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), hit ? 64'd0 : (err ? 64'd9 : 64'(delay + 2)));
        check("mreq_cycles", 64'(mreq_total - mreq0), hit ? 64'd0 : (err ? 64'd8 : 64'(delay)));
        check("fill_count", 64'(wen_total - wen0), (hit || err) ? 64'd0 : 64'd1);
        if (!hit && !err) begin
            check("fill_addr", 64'(last_waddr), 64'(addr));
            check("fill_data", 64'(last_wdata), 64'(data));
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    initial begin
        int wen0;
        int val0;
        rst = 1'b1;
        i_req = 1'b0;
        i_addr = 32'h1234_5678;
        late_ack = 1'b0;
        ack_delay = 0;
        exp_hits = 0;
        exp_misses = 0;
        mem_model[32'h100] = 32'h1111_2222;
        mem_model[32'h204] = 32'hDEAD_BEEF;
        mem_model[32'h284] = 32'h0BAD_F00D;
        mem_model[32'h300] = 32'h3333_3333;
        mem_model[32'h400] = 32'h4444_0400;
        mem_model[32'h500] = 32'h5555_0500;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_mreq", 64'(o_m_req), 64'd0);
        check("rst_cwen", 64'(o_c_wen), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_hit_cnt", 64'(o_hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(o_miss_cnt), 64'd0);
        check("idle_c_addr", 64'(o_c_addr), 64'h1234_5678);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch(32'h100, 1, 1'b1, 1'b0);  // prefilled hit
        fetch(32'h204, 3, 1'b0, 1'b0);  // miss, ack after 3 cycles
        fetch(32'h204, 1, 1'b1, 1'b0);  // now a hit
        fetch(32'h284, 1, 1'b0, 1'b0);  // same index, evicts 0x204
        fetch(32'h204, 2, 1'b0, 1'b0);  // misses again
        fetch(32'h600, 0, 1'b0, 1'b1);  // never acked: timeout

        // Reset while waiting on memory, then a stray ack.
        ack_delay = 0;
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_req", 64'(o_busy), 64'd1);
        wen0 = wen_total;
        val0 = valid_total;
        rst   = 1'b1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        check("rst_req_busy", 64'(o_busy), 64'd0);
        check("rst_req_mreq", 64'(o_m_req), 64'd0);
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("late_ack_fill", 64'(wen_total - wen0), 64'd0);
        check("late_ack_valid", 64'(valid_total - val0), 64'd0);
        check("late_ack_busy", 64'(o_busy), 64'd0);

        // Statistics from a clean reset.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        fetch(32'h100, 1, 1'b1, 1'b0);
        fetch(32'h204, 1, 1'b1, 1'b0);
        fetch(32'h100, 1, 1'b1, 1'b0);
        fetch(32'h400, 1, 1'b0, 1'b0);
        fetch(32'h500, 2, 1'b0, 1'b0);
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        check("hit_cnt", 64'(o_hit_cnt), 64'(exp_hits));
        check("miss_cnt", 64'(o_miss_cnt), 64'(exp_misses));
`else
        check("hit_cnt", 64'(o_hit_cnt), 64'd0);
        check("miss_cnt", 64'(o_miss_cnt), 64'd0);
`endif
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
